// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for conv_result_serializer.
//   DATA_W_DEF : default result element / output byte width
//   BEATS      : beats per frame (4 elements, plus a checksum beat when
//                RESULT_CHECKSUM_EN is defined)
//   IDX_W      : width of the beat index
//   state_t    : serializer FSM states (IDLE=0, SEND=1)
// Optional feature macro: RESULT_CHECKSUM_EN
package conv_pkg;

    localparam int DATA_W_DEF = 8;

`ifdef RESULT_CHECKSUM_EN
    localparam int BEATS = 5;
`else
    localparam int BEATS = 4;
`endif

    localparam int IDX_W = $clog2(BEATS);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/pulse_rise_detect.sv
// pulse_rise_detect: one-cycle pulse on the rising edge of a level input.
//   clk   : clock
//   rst   : asynchronous active-low reset (clears the history register)
//   level : input level to watch
//   rise  : high for the cycle where level=1 and the previous sample was 0
// Because history resets to 0, a level already high on the first clock after
// reset release is reported as a rise.
module pulse_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hist <= 1'b0;
        else      hist <= level;
    end

    assign rise = level & ~hist;

endmodule

// File: rtl/conv_result_serializer.sv
// conv_result_serializer: snapshots the 2x2 convolution result on a rising
// edge of done_in and streams it out one element per beat (c11, c12, c21, c22)
// on a valid/ready interface with an end-of-frame marker.
//   clk, rst          : clock, asynchronous active-low reset
//   done_in           : done level from the convolution core
//   c11, c12, c21, c22: result elements
//   out_data/out_valid/out_ready/out_last : byte stream, last on final beat
//   busy              : a frame is held or being sent
//   overrun           : sticky, a new result arrived while a frame was busy
// Optional feature macro: RESULT_CHECKSUM_EN adds a fifth beat carrying the
// mod-2^DATA_W sum of the four elements; out_last moves to that beat.
import conv_pkg::*;

module conv_result_serializer #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_in,
    input  logic [DATA_W-1:0] c11,
    input  logic [DATA_W-1:0] c12,
    input  logic [DATA_W-1:0] c21,
    input  logic [DATA_W-1:0] c22,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    state_t                        state, state_nxt;
    logic [IDX_W-1:0]              idx, idx_nxt;
    logic                          ovr_nxt;
    logic                          capture;
    logic                          rise;
    logic                          accept;
    logic                          final_acc;
    logic [BEATS-1:0][DATA_W-1:0]  shadow;
    logic [BEATS-1:0][DATA_W-1:0]  frame_in;

    pulse_rise_detect u_done_rise (
        .clk   (clk),
        .rst   (rst),
        .level (done_in),
        .rise  (rise)
    );

    // Frame image loaded into the shadow on capture, beat 0 first.
    always_comb begin
        frame_in    = '0;
        frame_in[0] = c11;
        frame_in[1] = c12;
        frame_in[2] = c21;
        frame_in[3] = c22;
`ifdef RESULT_CHECKSUM_EN
        frame_in[4] = c11 + c12 + c21 + c22;
`endif
    end

    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_last  = out_valid && (idx == LAST_IDX);
    assign out_data  = out_valid ? shadow[idx] : '0;
    assign accept    = out_valid & out_ready;
    assign final_acc = accept && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            overrun <= ovr_nxt;
        end
    end

    // Shadow only moves on capture, so c* may change freely mid-frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         shadow <= '0;
        else if (capture) shadow <= frame_in;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ovr_nxt   = overrun;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    capture   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (final_acc) begin
                    // A result landing on the final accept chains straight
                    // into the next frame with no bubble and no overrun.
                    idx_nxt = '0;
                    if (rise) capture   = 1'b1;
                    else      state_nxt = IDLE;
                end else begin
                    if (accept) idx_nxt = idx + 1'b1;
                    if (rise)   ovr_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_result_serializer.sv
// tb_conv_result_serializer: directed self-checking bench for
// conv_result_serializer (basic frame, backpressure, back-to-back, overrun,
// asynchronous reset mid-frame). Honors RESULT_CHECKSUM_EN for frame length.
module tb_conv_result_serializer;

`ifdef RESULT_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       done_in = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
    logic [7:0] out_data;
    logic       out_valid, out_last, busy, overrun;

    int checks = 0;
    int errors = 0;

    int fa[5] = '{28, 22, 29, 30, 109};
    int fb[5] = '{5, 6, 7, 8, 26};

    conv_result_serializer #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .done_in   (done_in),
        .c11       (c11),
        .c12       (c12),
        .c21       (c21),
        .c22       (c22),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input int a, input int b, input int c, input int d);
        c11 = 8'(a); c12 = 8'(b); c21 = 8'(c); c22 = 8'(d);
    endtask

    // Check beats from..NB-1 with out_ready=1, then the idle state after.
    task automatic run_rest(input int fr[5], input int from, input string tag);
        for (int i = from; i < NB; i++) begin
            chk({tag, "_data"}, 32'(out_data), 32'(fr[i]));
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_last"}, 32'(out_last), (i == NB - 1) ? 32'd1 : 32'd0);
            tick();
        end
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        rst = 1'b1;
        tick();
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Basic frame
        set_c(28, 22, 29, 30);
        done_in = 1'b1;
        tick();
        run_rest(fa, 0, "basic");
        done_in = 1'b0;
        tick();

        // Backpressure on beat 2
        done_in = 1'b1;
        tick();
        chk("bp_b0", 32'(out_data), 32'd28);
        tick();
        done_in = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_data", 32'(out_data), 32'd22);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_last", 32'(out_last), 32'd0);
        end
        out_ready = 1'b1;
        run_rest(fa, 1, "bp");

        // Back-to-back: capture lands on the final accept
        tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        for (int i = 0; i < NB; i++) begin
            chk("b2b_first", 32'(out_data), 32'(fa[i]));
            if (i == NB - 1) begin
                set_c(5, 6, 7, 8);
                done_in = 1'b1;
            end
            tick();
        end
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_data", 32'(out_data), 32'd5);
        chk("b2b_overrun", 32'(overrun), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        done_in = 1'b0;
        run_rest(fb, 0, "b2b");

        // Overrun: second rise while beat 1 is on the bus
        set_c(28, 22, 29, 30);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        tick();
        chk("ovr_b1", 32'(out_data), 32'd22);
        set_c(1, 2, 3, 4);
        done_in = 1'b1;
        tick();
        chk("ovr_set", 32'(overrun), 32'd1);
        run_rest(fa, 2, "ovr");
        chk("ovr_sticky", 32'(overrun), 32'd1);
        tick();
        chk("ovr_sticky2", 32'(overrun), 32'd1);
        chk("ovr_no_retrig", 32'(busy), 32'd0);

        // Asynchronous reset mid-frame, done_in held high across release
        done_in = 1'b0;
        tick();
        set_c(28, 22, 29, 30);
        done_in = 1'b1;
        tick();
        tick();
        chk("mrst_b1", 32'(out_data), 32'd22);
        #2 rst = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_overrun", 32'(overrun), 32'd0);
        chk("mrst_data", 32'(out_data), 32'd0);
        #3 rst = 1'b1;
        tick();
        chk("mrst_retrig_valid", 32'(out_valid), 32'd1);
        chk("mrst_retrig_data", 32'(out_data), 32'd28);
        done_in = 1'b0;
        run_rest(fa, 0, "mrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
